rs_encoder_lfsr: RTL and testbench
==================================

RS_ENCODER_LFSR -- requirements
Module: rs_encoder_lfsr

Interface
REQ-001 SHALL have parameter MSG_LEN, default 239, number of message symbols per codeword (fixed-length mode).
REQ-002 SHALL have parameter NUM_PARITY, default 16, number of parity symbols per codeword; legal values are even numbers 2..16.
REQ-003 SHALL have port clock, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, message symbol present.
REQ-006 SHALL have port in_ready, output, 1, encoder accepts a symbol this cycle.
REQ-007 SHALL have port in_data, input, 8, message symbol in GF(2^8).
REQ-008 SHALL have port in_last, input, 1, last message symbol; present only with RS_ENC_SHORTENED_EN.
REQ-009 SHALL have port out_valid, output, 1, codeword symbol present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts a symbol.
REQ-011 SHALL have port out_data, output, 8, codeword symbol.
REQ-012 SHALL have port out_parity, output, 1, out_data is a parity symbol.
REQ-013 SHALL have port out_last, output, 1, final parity symbol of the codeword.
REQ-014 SHALL have port busy, output, 1, state is not IDLE.

Function
REQ-015 SHALL produce a systematic RS codeword over GF(2^8), field polynomial 0x11D, alpha=0x02, with generator g(x)=prod_{i=0..NUM_PARITY-1}(x+alpha^i).
REQ-016 SHALL use the state machine IDLE -> DATA (on first accepted symbol) -> PARITY (after last message symbol accepted) -> IDLE (after last parity symbol is handed off).
REQ-017 SHALL assert in_ready = (state != PARITY) && (!out_valid || out_ready).
REQ-018 SHALL, on each accept (in_valid && in_ready), compute fb = in_data ^ r[NUM_PARITY-1], set r[0] = g0*fb and r[i] = r[i-1] ^ gi*fb, and load in_data into the output register with out_parity=0.
REQ-019 SHALL present each accepted message symbol on out_data exactly 1 cycle after acceptance (registered output).
REQ-020 SHALL, in PARITY, on every cycle with (!out_valid || out_ready), load out_data = r[NUM_PARITY-1] with out_parity=1, shift r up by one with r[0]=0, and increment the parity counter.
REQ-021 SHALL assert out_last together with the NUM_PARITY-th parity symbol, clear r, and return to IDLE when that symbol is handed off.
REQ-022 SHALL hold out_data, out_parity and out_last stable while out_valid && !out_ready.
REQ-023 SHALL count accepted message symbols in a 9-bit counter; in fixed mode the MSG_LEN-th accept triggers DATA -> PARITY.
REQ-024 SHALL emit the first parity symbol no earlier than the cycle after the last message symbol is handed off, giving exactly MSG_LEN+NUM_PARITY output handshakes per codeword with no gap when out_ready stays high.
REQ-025 SHALL ignore in_valid while in PARITY, with in_ready=0.

Reset
REQ-026 SHALL, on reset (including mid-codeword), force state=IDLE and clear r[], both counters, out_valid, out_parity and out_last; out_data=0, busy=0, in_ready=1 in the following cycle.

Configuration
REQ-027 SHALL, with RS_ENC_SHORTENED_EN defined, end the message on an accept with in_last=1 (1..MSG_LEN symbols); an accept at count MSG_LEN also ends the message regardless of in_last. Without the macro, the in_last port is absent and the length is always MSG_LEN.

Structure
REQ-028 SHALL take GF constants (field polynomial 0x11D, symbol width 8, N=255) and the generator coefficient table for NUM_PARITY=16 from the shared package rs_pkg, which the decoder blocks share.
REQ-029 SHALL instantiate NUM_PARITY copies of sub-module gf_mult_const (constant-coefficient GF(2^8) multiplier, parameter COEF).

Verification
REQ-030 SHALL cover: 239 zero symbols -> 255 outputs, all 16 parity symbols 0x00, out_last on output 255 only.
REQ-031 SHALL cover: 238 zeros then 0x01 -> parity symbols equal g15..g0 from rs_pkg, in that order.
REQ-032 SHALL cover: random message -> codeword evaluated at alpha^0..alpha^15 gives 0 (all syndromes zero).
REQ-033 SHALL cover: out_ready low for 5 cycles at parity symbol 3 -> out_data stable for those 5 cycles, in_ready=0, no symbol lost or duplicated.
REQ-034 SHALL cover: reset asserted after 100 accepted symbols -> busy=0 next cycle; the next 239-symbol message encodes identically to a fresh run.
REQ-035 SHALL cover, with RS_ENC_SHORTENED_EN: 3-symbol message {0x12,0x34,0x56} with in_last on the 3rd -> 19 outputs, out_last on the 19th, parity equal to that of 236 zeros followed by the same 3 symbols.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon GF(2^8) constants and helpers.
// Used by the encoder and the decoder blocks.
package rs_pkg;

  localparam int          SYM_W      = 8;
  localparam int          GF_N       = 255;
  localparam logic [8:0]  GF_POLY    = 9'h11D;
  localparam int          MAX_PARITY = 16;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [MAX_PARITY-1:0][SYM_W-1:0] gen_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY
  } enc_state_e;

  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  // g(x) = prod (x + alpha^i), i < n; index k holds coef of x^k
  function automatic gen_t gen_poly(int n);
    logic [MAX_PARITY:0][SYM_W-1:0] g;
    sym_t root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < MAX_PARITY; i++) begin
      if (i < n) begin
        for (int j = MAX_PARITY; j > 0; j--)
          g[j] = g[j-1] ^ gf_mul(g[j], root);
        g[0] = gf_mul(g[0], root);
        root = gf_mul(root, 8'h02);
      end
    end
    return g[MAX_PARITY-1:0];
  endfunction

  localparam gen_t GEN16 = gen_poly(16);

endpackage

// File: rtl/rs_encoder_lfsr_if.sv
// Symbol stream bundle for the RS encoder.
// RS_ENC_SHORTENED_EN adds in_last.
interface rs_encoder_lfsr_if;
  import rs_pkg::*;

  logic in_valid;
  logic in_ready;
  sym_t in_data;
`ifdef RS_ENC_SHORTENED_EN
  logic in_last;
`endif
  logic out_valid;
  logic out_ready;
  sym_t out_data;
  logic out_parity;
  logic out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef RS_ENC_SHORTENED_EN
    input  in_last,
`endif
    output in_ready, out_valid, out_data,
    output out_parity, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef RS_ENC_SHORTENED_EN
    output in_last,
`endif
    input  in_ready, out_valid, out_data,
    input  out_parity, out_last
  );

endinterface

// File: rtl/rs_encoder_lfsr_gf_mult.sv
// Constant-coefficient GF(2^8) multiplier.
// Folds to a small XOR network per COEF.
module gf_mult_const
  import rs_pkg::*;
#(
  parameter logic [7:0] COEF = 8'h01
) (
  input  sym_t a_i,
  output sym_t p_o
);

  // product with the fixed coefficient
  always_comb p_o = gf_mul(a_i, COEF);

endmodule

// File: rtl/rs_encoder_lfsr.sv
// Systematic RS(255-ish) LFSR encoder over GF(2^8).
// Optional macro RS_ENC_SHORTENED_EN: in_last ends a short message.
module rs_encoder_lfsr
  import rs_pkg::*;
#(
  parameter int MSG_LEN    = 239,
  parameter int NUM_PARITY = 16
) (
  input  logic                clock,
  input  logic                reset,
  rs_encoder_lfsr_if.slave    bus,
  output logic                busy
);

  localparam gen_t GEN =
    (NUM_PARITY == 16) ? GEN16 : gen_poly(NUM_PARITY);
  localparam int PW = $clog2(NUM_PARITY + 1);

  enc_state_e     state_q, state_d;
  sym_t           r_q [NUM_PARITY];
  sym_t           r_d [NUM_PARITY];
  sym_t           prod [NUM_PARITY];
  logic [8:0]     cnt_q, cnt_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic           ov_q, ov_d;
  sym_t           od_q, od_d;
  logic           op_q, op_d;
  logic           ol_q, ol_d;

  sym_t fb;
  logic adv;
  logic accept;
  logic msg_end;

  assign adv          = !ov_q || bus.out_ready;
  assign bus.in_ready = (state_q != ST_PARITY) && adv;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fb           = bus.in_data ^ r_q[NUM_PARITY-1];
`ifdef RS_ENC_SHORTENED_EN
  assign msg_end = accept &&
    (bus.in_last || cnt_q == 9'(MSG_LEN - 1));
`else
  assign msg_end = accept && (cnt_q == 9'(MSG_LEN - 1));
`endif

  assign bus.out_valid  = ov_q;
  assign bus.out_data   = od_q;
  assign bus.out_parity = op_q;
  assign bus.out_last   = ol_q;
  assign busy           = (state_q != ST_IDLE);

  for (genvar i = 0; i < NUM_PARITY; i++) begin : g_mul
    gf_mult_const #(.COEF(GEN[i])) u_mul (
      .a_i (fb),
      .p_o (prod[i])
    );
  end

  // next state: absorb message, then drain parity
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    op_d    = op_q;
    ol_d    = ol_q;
    unique case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          r_d[0] = prod[0];
          for (int i = 1; i < NUM_PARITY; i++)
            r_d[i] = r_q[i-1] ^ prod[i];
          cnt_d   = cnt_q + 9'd1;
          ov_d    = 1'b1;
          od_d    = bus.in_data;
          op_d    = 1'b0;
          ol_d    = 1'b0;
          state_d = msg_end ? ST_PARITY : ST_DATA;
        end else if (adv) begin
          ov_d = 1'b0;
        end
      end
      ST_PARITY: begin
        if (adv) begin
          if (pcnt_q == PW'(NUM_PARITY)) begin
            for (int i = 0; i < NUM_PARITY; i++)
              r_d[i] = '0;
            ov_d    = 1'b0;
            op_d    = 1'b0;
            ol_d    = 1'b0;
            cnt_d   = '0;
            pcnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            ov_d   = 1'b1;
            od_d   = r_q[NUM_PARITY-1];
            op_d   = 1'b1;
            ol_d   = (pcnt_q == PW'(NUM_PARITY - 1));
            r_d[0] = '0;
            for (int i = 1; i < NUM_PARITY; i++)
              r_d[i] = r_q[i-1];
            pcnt_d = pcnt_q + PW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_PARITY; i++)
        r_q[i] <= '0;
      cnt_q  <= '0;
      pcnt_q <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      op_q   <= 1'b0;
      ol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      op_q    <= op_d;
      ol_q    <= ol_d;
    end
  end

endmodule

// File: tb/tb_rs_encoder_lfsr.sv
// Directed scoreboard bench for rs_encoder_lfsr.
// Define RS_ENC_SHORTENED_EN to also run the short-message case.
module tb_rs_encoder_lfsr;
  import rs_pkg::*;

  localparam int ML = 239;
  localparam int NP = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       l;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;

  rs_encoder_lfsr_if bus ();

  rs_encoder_lfsr #(
    .MSG_LEN    (ML),
    .NUM_PARITY (NP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  int         par_seen = 0;
  exp_t       q[$];
  logic [7:0] cw[$];
  logic [7:0] ref_cw[$];
  logic [7:0] msg[ML];
  logic [7:0] gd[NP+1];
  logic       tb_last;

  function automatic logic [7:0] mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h00;
    s = b;
    for (int k = 7; k >= 0; k--) begin
      r = (r[7]) ? ((r << 1) ^ 8'h1D) : (r << 1);
      if (a[k]) r = r ^ s;
    end
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // generator, highest degree first: gd[0]=1 .. gd[NP]=g0
  task automatic build_gen();
    logic [7:0] a;
    a = 8'h01;
    for (int k = 0; k <= NP; k++) gd[k] = 8'h00;
    gd[0] = 8'h01;
    for (int i = 0; i < NP; i++) begin
      for (int k = i + 1; k >= 1; k--)
        gd[k] = gd[k] ^ mul(a, gd[k-1]);
      a = mul(a, 8'h02);
    end
  endtask

  // long division of m(x)*x^NP by g(x), push parity
  task automatic push_parity();
    logic [7:0] b[ML+NP];
    logic [7:0] c;
    for (int i = 0; i < ML + NP; i++)
      b[i] = (i < ML) ? msg[i] : 8'h00;
    for (int i = 0; i < ML; i++) begin
      c = b[i];
      for (int j = 0; j <= NP; j++)
        b[i+j] = b[i+j] ^ mul(c, gd[j]);
    end
    for (int k = 0; k < NP; k++)
      q.push_back({b[ML+k], 1'b1, (k == NP - 1)});
  endtask

  task automatic drive(input int start, input int cnt,
                       input bit use_last);
    for (int i = start; i < start + cnt; i++) begin
      bit ok;
      int t;
      ok = 1'b0;
      t  = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      tb_last = use_last && (i == start + cnt - 1);
`ifdef RS_ENC_SHORTENED_EN
      bus.in_last = tb_last;
`endif
      while (!ok && t < 1000) begin
        @(negedge clock);
        ok = bus.in_ready;
        if (ok) q.push_back({msg[i], 2'b00});
        @(posedge clock);
        #1;
        t++;
      end
      if (!ok) chk("in_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
    tb_last = 1'b0;
`ifdef RS_ENC_SHORTENED_EN
    bus.in_last = 1'b0;
`endif
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 3000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 3000) chk("done_timeout", 0, 1);
  endtask

  task automatic start_cw();
    q.delete();
    cw.delete();
    par_seen = 0;
  endtask

  // monitor: scoreboard pops and stall stability
  initial begin
    logic [9:0] hold;
    logic       stalled;
    exp_t       e;
    stalled = 1'b0;
    hold    = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          chk("stall_hold",
              {bus.out_valid, bus.out_data, bus.out_parity, bus.out_last},
              {1'b1, hold});
        if (bus.out_valid && !bus.out_ready && bus.out_parity)
          chk("stall_in_ready", bus.in_ready, 0);
        stalled = bus.out_valid && !bus.out_ready;
        hold    = {bus.out_data, bus.out_parity, bus.out_last};
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk("extra_out", {bus.out_data, bus.out_parity}, 9'h1FF);
          end else begin
            e = q.pop_front();
            chk("out_sym",
                {bus.out_data, bus.out_parity, bus.out_last}, e);
          end
          cw.push_back(bus.out_data);
          if (bus.out_parity) par_seen++;
        end
      end
    end
  end

  initial begin
    logic [7:0] a;
    logic [7:0] s;
    int         t;
    int         bad;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    tb_last       = 1'b0;
`ifdef RS_ENC_SHORTENED_EN
    bus.in_last = 1'b0;
`endif
    build_gen();

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out", {bus.out_data, bus.out_parity, bus.out_last}, 0);
    reset = 1'b0;

    // all-zero message
    start_cw();
    for (int i = 0; i < ML; i++) msg[i] = 8'h00;
    drive(0, ML, 1'b0);
    push_parity();
    wait_done();
    chk("zero_len", cw.size(), ML + NP);
    chk("zero_busy_end", busy, 0);

    // single 0x01 at the end: parity is g15..g0
    start_cw();
    msg[ML-1] = 8'h01;
    drive(0, ML, 1'b0);
    push_parity();
    wait_done();
    for (int k = 0; k < NP; k++) begin
      chk("unit_par", cw[ML+k], gd[k+1]);
      chk("pkg_gen", GEN16[NP-1-k], gd[k+1]);
    end

    // random message: all syndromes zero
    start_cw();
    for (int i = 0; i < ML; i++) msg[i] = 8'($urandom_range(0, 255));
    drive(0, ML, 1'b0);
    push_parity();
    wait_done();
    chk("rand_len", cw.size(), ML + NP);
    a = 8'h01;
    for (int j = 0; j < NP; j++) begin
      s = 8'h00;
      foreach (cw[i]) s = mul(s, a) ^ cw[i];
      chk("syndrome", s, 0);
      a = mul(a, 8'h02);
    end
    ref_cw = cw;

    // back-pressure on parity symbol 3, input offered
    start_cw();
    drive(0, ML, 1'b0);
    push_parity();
    t = 0;
    while (!(bus.out_valid && bus.out_parity && par_seen == 3)
           && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 2000) chk("stall_wait", 0, 1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    wait_done();
    chk("stall_len", cw.size(), ML + NP);

    // reset after 100 symbols, then re-encode
    start_cw();
    drive(0, 100, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out",
        {bus.out_valid, bus.out_data, bus.out_parity, bus.out_last}, 0);
    start_cw();
    drive(0, ML, 1'b0);
    push_parity();
    wait_done();
    bad = 0;
    if (cw.size() != ref_cw.size()) bad = 1;
    else foreach (cw[i]) if (cw[i] !== ref_cw[i]) bad++;
    chk("rerun_same", bad, 0);

`ifdef RS_ENC_SHORTENED_EN
    // shortened 3-symbol message
    start_cw();
    for (int i = 0; i < ML; i++) msg[i] = 8'h00;
    msg[ML-3] = 8'h12;
    msg[ML-2] = 8'h34;
    msg[ML-1] = 8'h56;
    drive(ML - 3, 3, 1'b1);
    push_parity();
    wait_done();
    chk("short_len", cw.size(), 3 + NP);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
